// File: rtl/minterm_sweep.sv
// rtl/minterm_sweep.sv - sweeps all input vectors of a 4-input function, captures and checks its truth table
module minterm_sweep #(
    parameter int                     N_IN   = 4,
    parameter int                     SETTLE = 2,
    parameter logic [(1<<N_IN)-1:0]   EXPECT = 16'h001E
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start_i,
    output logic [N_IN-1:0]           vec_o,
    input  logic                      y_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic [(1<<N_IN)-1:0]      table_o,
    output logic [N_IN:0]             err_cnt_o,
    output logic                      err_valid_o,
    output logic [N_IN-1:0]           first_err_o,
    output logic                      pass_o
);

    localparam int              NV          = 1 << N_IN;
    // Counter value on which the current vector is sampled; SETTLE is limited to 1..255.
    localparam logic [7:0]      SETTLE_LAST = 8'(SETTLE - 1);
    localparam logic [N_IN-1:0] IDX_LAST    = {N_IN{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SWEEP = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            state_q;
    logic [N_IN-1:0]   idx_q;
    logic [7:0]        cnt_q;
    logic              busy_q;
    logic              done_q;
    logic [NV-1:0]     table_q;
    logic [N_IN:0]     err_cnt_q;
    logic              err_valid_q;
    logic [N_IN-1:0]   first_err_q;
    logic              pass_q;

    logic              sample_hit;
    logic              miss;
    logic [N_IN:0]     err_cnt_d;

    // Sample strobe, mismatch detect and the error count as it will be after this edge.
    always_comb begin
        sample_hit = 1'b0;
        miss       = 1'b0;
        err_cnt_d  = err_cnt_q;
        if (state_q == S_SWEEP && cnt_q == SETTLE_LAST) begin
            sample_hit = 1'b1;
            miss       = (y_i != EXPECT[idx_q]);
            if (miss) begin
                err_cnt_d = err_cnt_q + 1'b1;
            end
        end
    end

    // Sweep sequencer: idx is the applied vector, so it rests at 0 outside SWEEP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            table_q     <= '0;
            err_cnt_q   <= '0;
            err_valid_q <= 1'b0;
            first_err_q <= '0;
            pass_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        state_q     <= S_SWEEP;
                        busy_q      <= 1'b1;
                        idx_q       <= '0;
                        cnt_q       <= '0;
                        table_q     <= '0;
                        err_cnt_q   <= '0;
                        err_valid_q <= 1'b0;
                        first_err_q <= '0;
                        pass_q      <= 1'b0;
                    end
                end
                S_SWEEP: begin
                    if (sample_hit) begin
                        cnt_q          <= '0;
                        table_q[idx_q] <= y_i;
                        err_cnt_q      <= err_cnt_d;
                        if (miss && !err_valid_q) begin
                            err_valid_q <= 1'b1;
                            first_err_q <= idx_q;
                        end
                        idx_q <= idx_q + 1'b1;
                        if (idx_q == IDX_LAST) begin
                            // Last vector: results are final from this edge on.
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (err_cnt_d == '0);
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    idx_q   <= '0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign vec_o       = idx_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign table_o     = table_q;
    assign err_cnt_o   = err_cnt_q;
    assign err_valid_o = err_valid_q;
    assign first_err_o = first_err_q;
    assign pass_o      = pass_q;

endmodule

// File: tb/tb_minterm_sweep.sv
// tb/tb_minterm_sweep.sv - directed-vector bench for minterm_sweep at SETTLE 2 and 1
module tb_minterm_sweep;

    logic        clk;
    logic        rst_n;
    logic        start2, start1;
    logic        y2, y1;
    logic [3:0]  vec2, vec1;
    logic        busy2, busy1, done2, done1;
    logic [15:0] tbl2, tbl1;
    logic [4:0]  ec2, ec1;
    logic        ev2, ev1, pass2, pass1;
    logic [3:0]  fe2, fe1;

    // 0 = function, 1 = stuck-at-0, 2 = stuck-at-1, 3 = function through one register (SETTLE=1 DUT only)
    int          mode;
    logic        sel;
    logic        y_dly;

    int          n_checks;
    int          n_fail;

    minterm_sweep #(.N_IN(4), .SETTLE(2), .EXPECT(16'h001E)) u_s2 (
        .clk(clk), .rst_n(rst_n), .start_i(start2), .vec_o(vec2), .y_i(y2),
        .busy_o(busy2), .done_o(done2), .table_o(tbl2), .err_cnt_o(ec2),
        .err_valid_o(ev2), .first_err_o(fe2), .pass_o(pass2)
    );

    minterm_sweep #(.N_IN(4), .SETTLE(1), .EXPECT(16'h001E)) u_s1 (
        .clk(clk), .rst_n(rst_n), .start_i(start1), .vec_o(vec1), .y_i(y1),
        .busy_o(busy1), .done_o(done1), .table_o(tbl1), .err_cnt_o(ec1),
        .err_valid_o(ev1), .first_err_o(fe1), .pass_o(pass1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic fn(input logic [3:0] v);
        return (v >= 4'd1 && v <= 4'd4);
    endfunction

    always_ff @(posedge clk) y_dly <= fn(vec1);

    assign y2 = (mode == 1) ? 1'b0 : (mode == 2) ? 1'b1 : fn(vec2);
    assign y1 = (mode == 3) ? y_dly : fn(vec1);

    // Observation mux over the DUT under test
    logic        o_busy, o_done, o_ev, o_pass;
    logic [15:0] o_tbl;
    logic [4:0]  o_ec;
    logic [3:0]  o_fe, o_vec;
    assign o_busy = sel ? busy1 : busy2;
    assign o_done = sel ? done1 : done2;
    assign o_ev   = sel ? ev1   : ev2;
    assign o_pass = sel ? pass1 : pass2;
    assign o_tbl  = sel ? tbl1  : tbl2;
    assign o_ec   = sel ? ec1   : ec2;
    assign o_fe   = sel ? fe1   : fe2;
    assign o_vec  = sel ? vec1  : vec2;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_start(input logic v);
        if (sel) start1 = v;
        else     start2 = v;
    endtask

    // Start a sweep, count busy cycles and locate done (cycle 1 = cycle after the accepting edge).
    // Returns in the IDLE cycle following DONE.
    task automatic run(input int extra_at, input logic start_in_done,
                       output int busy_n, output int done_at);
        int cyc;
        @(negedge clk) set_start(1'b1);
        @(negedge clk) set_start(1'b0);
        cyc     = 1;
        busy_n  = 0;
        done_at = 0;
        while (cyc <= 200) begin
            if (o_busy) busy_n++;
            if (o_done) begin
                done_at = cyc;
                break;
            end
            set_start(cyc == extra_at);
            @(negedge clk);
            cyc++;
        end
        check_eq("done_seen", {31'd0, done_at != 0}, 32'd1);
        set_start(start_in_done);
        @(negedge clk);
        set_start(1'b0);
    endtask

    task automatic check_results(input string tag, input logic [15:0] t, input logic [4:0] ec,
                                 input logic ev, input logic [3:0] fe, input logic ps);
        check_eq({tag, "_table"},     {16'd0, o_tbl}, {16'd0, t});
        check_eq({tag, "_err_cnt"},   {27'd0, o_ec},  {27'd0, ec});
        check_eq({tag, "_err_valid"}, {31'd0, o_ev},  {31'd0, ev});
        check_eq({tag, "_first_err"}, {28'd0, o_fe},  {28'd0, fe});
        check_eq({tag, "_pass"},      {31'd0, o_pass}, {31'd0, ps});
    endtask

    initial begin
        int bn, da, cyc, dseen;
        n_checks = 0;
        n_fail   = 0;
        mode     = 0;
        sel      = 1'b0;
        start1   = 1'b0;
        start2   = 1'b0;
        rst_n    = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", {31'd0, busy2}, 32'd0);
        check_eq("rst_done", {31'd0, done2}, 32'd0);
        check_eq("rst_vec",  {28'd0, vec2},  32'd0);
        check_results("rst", 16'h0000, 5'd0, 1'b0, 4'd0, 1'b0);
        check_eq("rst_s1_busy_table", {15'd0, busy1, tbl1}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Correct function, SETTLE = 2
        run(0, 1'b0, bn, da);
        check_eq("func_busy_cycles", bn, 32);
        check_eq("func_done_cycle",  da, 33);
        check_results("func", 16'h001E, 5'd0, 1'b0, 4'd0, 1'b1);
        check_eq("func_done_one_cycle", {31'd0, o_done}, 32'd0);

        // Stuck-at-0
        mode = 1;
        run(0, 1'b0, bn, da);
        check_results("sa0", 16'h0000, 5'd4, 1'b1, 4'd1, 1'b0);

        // Stuck-at-1, then a start in the cycle after done is accepted
        mode = 2;
        run(0, 1'b0, bn, da);
        check_results("sa1", 16'hFFFF, 5'd12, 1'b1, 4'd0, 1'b0);
        set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);
        check_eq("restart_busy",  {31'd0, o_busy}, 32'd1);
        check_eq("restart_table", {16'd0, o_tbl},  32'd0);
        check_eq("restart_err",   {27'd0, o_ec},   32'd0);
        cyc = 0;
        while (!o_done && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("restart_done_seen", {31'd0, o_done}, 32'd1);
        @(negedge clk);

        // Start ignored at sweep cycle 10 and during done
        mode = 0;
        run(10, 1'b1, bn, da);
        check_eq("ign_busy_cycles", bn, 32);
        check_eq("ign_done_cycle",  da, 33);
        check_results("ign", 16'h001E, 5'd0, 1'b0, 4'd0, 1'b1);
        check_eq("ign_no_restart", {30'd0, o_busy, o_done}, 32'd0);

        // Reset at sweep cycle 15
        @(negedge clk) set_start(1'b1);
        @(negedge clk) set_start(1'b0);
        repeat (14) @(negedge clk);
        check_eq("pre_rst_table", {16'd0, o_tbl}, 32'h001E);
        #1 rst_n = 1'b0;
        #1;
        check_eq("arst_busy_vec", {27'd0, o_busy, o_vec}, 32'd0);
        check_results("arst", 16'h0000, 5'd0, 1'b0, 4'd0, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dseen = 0;
        repeat (40) begin
            @(negedge clk);
            if (o_done) dseen++;
        end
        check_eq("arst_no_done", dseen, 0);
        run(0, 1'b0, bn, da);
        check_eq("post_rst_busy_cycles", bn, 32);
        check_results("post_rst", 16'h001E, 5'd0, 1'b0, 4'd0, 1'b1);

        // SETTLE = 1
        sel = 1'b1;
        run(0, 1'b0, bn, da);
        check_eq("s1_busy_cycles", bn, 16);
        check_eq("s1_done_cycle",  da, 17);
        check_results("s1", 16'h001E, 5'd0, 1'b0, 4'd0, 1'b1);

        // SETTLE = 1 with y one register late: bit k shows fn(k-1)
        mode = 3;
        run(0, 1'b0, bn, da);
        check_results("s1_dly", 16'h003C, 5'd2, 1'b1, 4'd1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
